riscv_dcache_ctrl: RTL

- Miss-handling controller for the data cache; sits directly downstream of the tag array and consumes its combinational hit/dirty outputs.
- Drives the tag-array update controls (replace_tag, valid_in, dirty_in), data-array write strobes, and the multi-beat writeback/refill handshake to main memory.
- Stalls the core pipeline from miss detection until the refilled line is installed.

---
 rtl/riscv_dcache_pkg.sv | 5 +
 rtl/riscv_dcache_ctrl_if.sv | 32 +++
 rtl/riscv_dcache_sat_cnt.sv | 14 +
 rtl/riscv_dcache_ctrl.sv | 79 +++++++
 4 files changed

// File: rtl/riscv_dcache_pkg.sv
// riscv_dcache_pkg: shared state type and line geometry for the data-cache miss controller
package riscv_dcache_pkg;
    typedef enum logic [1:0] {IDLE, WRITE_BACK, ALLOCATE, UPDATE} dcache_state_e;
    localparam int DEF_BLOCK_BEATS = 4;
endpackage

// File: rtl/riscv_dcache_ctrl_if.sv
// riscv_dcache_ctrl_if: core request, tag-array and memory-burst signals of the miss controller
interface riscv_dcache_ctrl_if
    import riscv_dcache_pkg::*;
#(
    parameter int BEAT_W = $clog2(DEF_BLOCK_BEATS)
) ();
    logic              cpu_rd_req;
    logic              cpu_wr_req;
    logic              hit;
    logic              dirty;
    logic              mem_ready;
    logic              stall;
    logic              replace_tag;
    logic              valid_in;
    logic              dirty_in;
    logic              cache_wr_en;
    logic              fill_we;
    logic              mem_rd_req;
    logic              mem_wr_req;
    logic              addr_sel;
    logic [BEAT_W-1:0] beat_cnt;
    modport slave (
        input  cpu_rd_req, cpu_wr_req, hit, dirty, mem_ready,
        output stall, replace_tag, valid_in, dirty_in, cache_wr_en, fill_we,
        output mem_rd_req, mem_wr_req, addr_sel, beat_cnt
    );
    modport master (
        output cpu_rd_req, cpu_wr_req, hit, dirty, mem_ready,
        input  stall, replace_tag, valid_in, dirty_in, cache_wr_en, fill_we,
        input  mem_rd_req, mem_wr_req, addr_sel, beat_cnt
    );
endinterface

// File: rtl/riscv_dcache_sat_cnt.sv
// riscv_dcache_sat_cnt: event counter that sticks at all-ones instead of wrapping
module riscv_dcache_sat_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] q
);
    // count up on inc until saturated
    always_ff @(posedge clk or posedge rst)
        if (rst) q <= '0;
        else if (inc && q != '1) q <= q + 1'b1;
endmodule

// File: rtl/riscv_dcache_ctrl.sv
// riscv_dcache_ctrl: data-cache miss FSM driving tag updates, fills and writeback/refill bursts
module riscv_dcache_ctrl
    import riscv_dcache_pkg::*;
#(
    parameter int BLOCK_BEATS = DEF_BLOCK_BEATS,
    parameter int BEAT_W      = $clog2(BLOCK_BEATS),
    parameter int CNT_W       = 32
) (
    input  logic                clk,
    input  logic                rst,
    riscv_dcache_ctrl_if.slave  bus,
    output logic [CNT_W-1:0]    miss_cnt,
    output logic [CNT_W-1:0]    wb_cnt
);
    dcache_state_e     state, state_nx;
    logic [BEAT_W-1:0] beat_q, beat_nx;
    logic              req, store, last, miss;
    // rst also masks the Mealy request path so every output reads 0 while reset is held
    assign req   = (bus.cpu_rd_req | bus.cpu_wr_req) & ~rst;
    assign store = bus.cpu_wr_req;
    assign last  = beat_q == BEAT_W'(BLOCK_BEATS - 1);
    assign miss  = state == IDLE && req && !bus.hit;
    assign bus.beat_cnt = beat_q;
    // state and beat registers; reset aborts any burst in flight
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state  <= IDLE;
            beat_q <= '0;
        end else begin
            state  <= state_nx;
            beat_q <= beat_nx;
        end
    // next-state and output decode; beat counter wraps to 0 naturally on the last beat
    always_comb begin
        state_nx        = state;
        beat_nx         = beat_q;
        bus.stall       = 1'b0;
        bus.replace_tag = 1'b0;
        bus.valid_in    = 1'b0;
        bus.dirty_in    = 1'b0;
        bus.cache_wr_en = 1'b0;
        bus.fill_we     = 1'b0;
        bus.mem_rd_req  = 1'b0;
        bus.mem_wr_req  = 1'b0;
        bus.addr_sel    = 1'b0;
        case (state)
            IDLE: begin
                bus.cache_wr_en = req && bus.hit && store;
                bus.replace_tag = bus.cache_wr_en;
                bus.valid_in    = bus.cache_wr_en;
                bus.dirty_in    = bus.cache_wr_en;
                bus.stall       = miss;
                state_nx        = !miss ? IDLE : bus.dirty ? WRITE_BACK : ALLOCATE;
            end
            WRITE_BACK: begin
                bus.stall      = 1'b1;
                bus.mem_wr_req = 1'b1;
                bus.addr_sel   = 1'b1;
                beat_nx        = bus.mem_ready ? beat_q + 1'b1 : beat_q;
                state_nx       = bus.mem_ready && last ? ALLOCATE : WRITE_BACK;
            end
            ALLOCATE: begin
                bus.stall      = 1'b1;
                bus.mem_rd_req = 1'b1;
                bus.fill_we    = bus.mem_ready;
                beat_nx        = bus.mem_ready ? beat_q + 1'b1 : beat_q;
                state_nx       = bus.mem_ready && last ? UPDATE : ALLOCATE;
            end
            default: begin
                bus.stall       = 1'b1;
                bus.replace_tag = 1'b1;
                bus.valid_in    = 1'b1;
                state_nx        = IDLE;
            end
        endcase
    end
    riscv_dcache_sat_cnt #(.CNT_W(CNT_W)) u_miss_cnt (.clk(clk), .rst(rst), .inc(miss), .q(miss_cnt));
    riscv_dcache_sat_cnt #(.CNT_W(CNT_W)) u_wb_cnt (.clk(clk), .rst(rst), .inc(miss && bus.dirty), .q(wb_cnt));
endmodule
